// File: rtl/mem_responder.sv
// Memory-side responder: word-addressed SRAM with byte-enabled writes and tagged,
// fixed-latency read responses delivered in order through a credit-bounded queue.
module mem_responder #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TAG_WIDTH      = 6,
  parameter int LATENCY        = 2,
  parameter int RSP_QUEUE_SIZE = 4,
  parameter int DATA_SIZE      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_rw,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_SIZE-1:0]  req_byteen,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  input  logic                  rsp_ready
);

  localparam int PTR_W = $clog2(RSP_QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  rd_acc;
  logic                  wr_acc;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic [DATA_WIDTH-1:0] push_data;
  logic [TAG_WIDTH-1:0]  push_tag;

  logic [CNT_W-1:0]      credit_q, credit_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] q_data_q [RSP_QUEUE_SIZE];
  logic [TAG_WIDTH-1:0]  q_tag_q  [RSP_QUEUE_SIZE];

  // Credits cover every read from accept until its response leaves the queue,
  // so the queue can never overflow and the pipeline never needs to stall.
  assign req_ready = (credit_q < CNT_W'(RSP_QUEUE_SIZE));
  assign rd_acc    = req_valid && req_ready && !req_rw;
  assign wr_acc    = req_valid && req_ready && req_rw;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int b = 0; b < DATA_SIZE; b++) begin
        if (req_byteen[b]) mem_q[req_addr][b*8 +: 8] <= req_data[b*8 +: 8];
      end
    end
  end

  // The queue entry itself is the last latency stage, hence LATENCY-1 registers here.
  generate
    if (LATENCY == 1) begin : g_no_pipe
      assign push      = rd_acc;
      assign push_data = mem_q[req_addr];
      assign push_tag  = req_tag;
    end else begin : g_pipe
      localparam int NS = LATENCY - 1;

      logic [NS-1:0]         vld_q, vld_d;
      logic [DATA_WIDTH-1:0] data_q [NS];
      logic [DATA_WIDTH-1:0] data_d [NS];
      logic [TAG_WIDTH-1:0]  tag_q  [NS];
      logic [TAG_WIDTH-1:0]  tag_d  [NS];

      always_comb begin
        vld_d[0]  = rd_acc;
        data_d[0] = mem_q[req_addr];
        tag_d[0]  = req_tag;
        for (int i = 1; i < NS; i++) begin
          vld_d[i]  = vld_q[i-1];
          data_d[i] = data_q[i-1];
          tag_d[i]  = tag_q[i-1];
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_q <= '0;
        else       vld_q <= vld_d;
      end

      always_ff @(posedge clk) begin
        data_q <= data_d;
        tag_q  <= tag_d;
      end

      assign push      = vld_q[NS-1];
      assign push_data = data_q[NS-1];
      assign push_tag  = tag_q[NS-1];
    end
  endgenerate

  assign full      = (count_q == CNT_W'(RSP_QUEUE_SIZE));
  assign rsp_valid = (count_q != '0);
  assign rsp_data  = q_data_q[rd_ptr_q];
  assign rsp_tag   = q_tag_q[rd_ptr_q];
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = credit_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case ({rd_acc, pop})
      2'b10:   credit_d = credit_q + CNT_W'(1);
      2'b01:   credit_d = credit_q - CNT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_data_q[wr_ptr_q] <= push_data;
      q_tag_q[wr_ptr_q]  <= push_tag;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop))
    else $error("response queue push while full without pop");

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the tagged request/response interface produced by the memory arbiter. It terminates one request stream and services it from a local word-addressed SRAM model.
- Reads return data with the request tag echoed unchanged, after a fixed pipeline latency. Writes are absorbed with no response.
- Used as the back-end in cluster-level test harnesses and as a small on-chip scratch memory behind an arbiter.

Parameters:
DATA_WIDTH, 32, data bus width in bits (multiple of 8)
ADDR_WIDTH, 8, word address width; memory depth = 2^ADDR_WIDTH words
TAG_WIDTH, 6, request/response tag width; tag is opaque to this block
LATENCY, 2, read latency in cycles from request accept to response valid (>=1)
RSP_QUEUE_SIZE, 4, response queue depth and maximum outstanding reads (power of 2, >=2)
DATA_SIZE, DATA_WIDTH/8, byte-enable width (derived)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
req_valid  input  1  request valid
req_rw  input  1  1 = write, 0 = read
req_addr  input  ADDR_WIDTH  word address
req_byteen  input  DATA_SIZE  write byte enables (ignored for reads)
req_data  input  DATA_WIDTH  write data
req_tag  input  TAG_WIDTH  request tag
req_ready  output  1  request accepted when req_valid && req_ready
rsp_valid  output  1  read response valid
rsp_data  output  DATA_WIDTH  read data
rsp_tag  output  TAG_WIDTH  tag of the originating read
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready

Behaviour:
- Interface: one clock clk; reset is asynchronous and active-high, named reset.
- Reset:
  - Clears the pipeline valid bits, the response queue pointers and the credit counter.
  - Output values during and after reset: rsp_valid=0, req_ready=1, rsp_data/rsp_tag don't-care.
  - SRAM contents are not reset.
  - Reset mid-operation discards all in-flight reads and queued responses; no response for them ever appears.
- Credits:
  - credit_cnt (width clog2(RSP_QUEUE_SIZE)+1) counts reads in the pipeline plus entries in the response queue.
  - Read accept: +1. Response handshake: -1. Both in the same cycle: unchanged.
  - Writes do not change credit_cnt.
- req_ready = (credit_cnt < RSP_QUEUE_SIZE).
  - Registered-state function only; never depends on req_valid, req_rw or rsp_ready.
  - Applies to reads and writes alike.
- Write accept:
  - At the accept edge, byte i of mem[req_addr] is updated with req_data byte i where req_byteen[i]=1.
  - No response and no pipeline entry.
- Read accept:
  - At the accept edge, mem[req_addr] and req_tag are captured into pipeline stage 1.
  - The read then advances through LATENCY-1 further stages.
  - Stages never stall; the credit scheme guarantees queue space.
  - At the edge ending stage LATENCY, data and tag are pushed into the response queue.
- Ordering and hazards:
  - A read accepted the cycle after a write to the same address returns the new data.
  - Only one request is accepted per cycle, so there is no same-cycle read/write hazard.
- Response queue:
  - FIFO of RSP_QUEUE_SIZE entries of {tag, data}.
  - rsp_valid, rsp_data and rsp_tag are driven directly from the head entry.
  - Responses are delivered in request order.
- Latency: a read accepted in cycle t, with an empty queue, has rsp_valid=1 in cycle t+LATENCY.
- Push and pop in the same cycle:
  - Allowed at any occupancy, including full.
  - The count is unchanged and the pointers advance modulo RSP_QUEUE_SIZE.
- Boundary conditions:
  - Queue overflow is impossible by construction.
  - Assertion: a push while the queue is full without a same-cycle pop is an error.
  - rsp_valid, once asserted, holds with stable data and tag until the handshake.
  - req_valid=0 has no effect; request fields are ignored.

Test Plan:
- Write-then-read: write addr 0x10 data 0xDEADBEEF byteen 0xF; next cycle read addr 0x10 tag 0x2A -> rsp_valid exactly LATENCY=2 cycles after the read accept; rsp_data=0xDEADBEEF, rsp_tag=0x2A.
- Partial write: mem[0x05]=0x11223344, then write 0xAABBCCDD byteen 0x5; read -> 0x11BB33DD.
- Backpressure: rsp_ready=0, issue 5 back-to-back reads with tags 1..5 -> reads 1-4 accepted, req_ready=0 from the cycle after the 4th accept, read 5 stalled. Raise rsp_ready -> responses arrive in order 1,2,3,4. Read 5 is accepted the cycle after the first pop and returns last.
- Full-queue simultaneous events: credit_cnt=4, rsp_ready=1 held -> req_ready re-asserts the cycle after each pop. Streaming reads then sustain one response per cycle with no bubbles or duplicates.
- Reset mid-operation: 3 reads outstanding, assert reset for 1 cycle asynchronously -> rsp_valid=0 and req_ready=1 immediately. No stale responses afterwards. A prior write to 0x20 is still readable.
- Writes under zero credit: credit_cnt=4, write with req_valid=1 -> not accepted until req_ready=1; memory unchanged until then.
